uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART. It detects the start bit on the serial line and runs a 16x-oversampled state machine that samples the start, data and stop bits at mid-bit. The received word is presented on a valid/ready handshake. It also drives the 2-bit select that steers the 3-way, 3-bit RX datapath mux according to the current frame phase.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; must be an even value of at least 4
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_i  in  1  serial line input, asynchronous, idle high
data_o  out  DATA_BITS  received word
valid_o  out  1  data_o holds an unconsumed word
ready_i  in  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  out  1  one-cycle pulse when the stop bit samples low
overrun_o  out  1  one-cycle pulse when a frame completes while the previous word is unconsumed
mux_sel_o  out  2  frame-phase select for the RX datapath mux: 00 idle/start, 01 data, 10 stop; 11 is never driven

Behaviour:
- Reset: rst_n sampled low at a clk edge produces the following state:
  - state = IDLE; all counters = 0; synchroniser flops = 1.
  - data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, mux_sel_o = 00.
  - Reset mid-frame discards the partial word.
- Input sync: rx_i passes through 2 flops (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer-truncated and clamped to a minimum of 1.
  - tick pulses for 1 cycle every DIV clocks.
  - The tick counter free-runs, but is restarted (count 0) on the IDLE->START transition.
- States and transitions:
  - IDLE: rx_s == 0 -> START. Clear os_cnt and bit_cnt.
  - START: count ticks. At os_cnt == OVERSAMPLE/2-1:
    - rx_s == 1 is a glitch -> IDLE, with no error.
    - rx_s == 0 -> DATA, clear os_cnt.
  - DATA: at os_cnt == OVERSAMPLE-1, sample rx_s into shift register bit bit_cnt (LSB first). Increment bit_cnt and clear os_cnt. After sampling bit DATA_BITS-1 -> STOP (or PARITY when the optional feature is compiled in).
  - STOP: at os_cnt == OVERSAMPLE-1, sample rx_s.
    - 1 -> complete the frame.
    - 0 -> frame_err_o pulses; the word is dropped and valid_o is unaffected.
    - Either way -> IDLE.
    - A line still low after a framing error is treated as a new start edge on the next cycle.
- Mux select mapping: mux_sel_o is a registered decode of the next state: IDLE/START -> 00, DATA/PARITY -> 01, STOP -> 10.
- Frame completion rules:
  - valid_o == 0: data_o <= shift register, and valid_o rises on the next edge.
  - valid_o == 1 and ready_i == 0: data_o is kept, overrun_o pulses, and the new word is dropped.
  - valid_o == 1 and ready_i == 1 in the same cycle: the old word is consumed, the new word is loaded, valid_o stays 1, and there is no overrun.
- Handshake: valid_o falls on the edge after valid_o && ready_i. data_o is stable while valid_o == 1.
- Latency: valid_o rises 1 clk after the stop-bit mid-sample. Error pulses are exactly 1 cycle wide.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled at its mid-bit.
  - Parity is even: XOR of the data bits and the parity bit must equal 0.
  - On mismatch, parity_err_o (an extra 1-bit output port, reset 0) pulses 1 cycle at the stop sample. The word is still delivered.
- Undefined: no PARITY state, no parity_err_o port, and the frame is 1+DATA_BITS+1 bits.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Select constants SEL_START=2'b00, SEL_DATA=2'b01, SEL_STOP=2'b10.
  - Function to compute DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_tick: divider with a restart input and a tick output, instantiated once.

Test Plan:
All scenarios use CLK_FREQ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 (DIV=1, 16 clk per bit).
1. Frame 0xA5 with stop=1, ready_i=1 -> valid_o for 1 cycle with data_o=0xA5. mux_sel_o sequence is 00, then 01 for 8 bit periods, then 10, then 00.
2. Low glitch of 4 clk on an idle line -> return to IDLE, no valid_o, no frame_err_o.
3. Frame 0x3C with stop=0 -> frame_err_o pulses once, valid_o stays 0.
4. Frames 0x11 then 0x22 with ready_i=0 -> data_o=0x11 held, overrun_o pulses at completion of the second frame. Raising ready_i then consumes 0x11 and valid_o falls.
5. ready_i asserted in the exact cycle the second frame completes -> data_o=0x22, valid_o stays 1, overrun_o=0.
6. rst_n low during data bit 3 -> all outputs 0 next edge. A following clean 0x5A frame is received correctly. With UART_RX_PARITY_EN, 0x5A with parity=1 makes parity_err_o pulse once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Optional parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_STOP  = 2'b10;

    // Clocks per oversample tick, never below one.
    function automatic int unsigned calc_div(
        input int unsigned clk_freq,
        input int unsigned baud,
        input int unsigned os
    );
        int unsigned d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    // Datapath mux select for a given frame phase.
    function automatic logic [1:0] state_sel(input rx_state_t s);
        logic [1:0] sel;
        sel = SEL_START;
        unique case (s)
            DATA, PARITY: sel = SEL_DATA;
            STOP:         sel = SEL_STOP;
            default:      sel = SEL_START;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; restart_i realigns the count to a start edge.
// Fixed-ratio divider, no build options.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));

    // Free-running count, wraps on tick or restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampled mid-bit sampling, valid/ready out.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err_o.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic [1:0]           mux_sel_o
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned OW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam logic [OW-1:0] HALF_M1 = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] FULL_M1 = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q, state_d;
    logic [OW-1:0]        os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic [1:0]           sel_q;
    logic                 tick, restart, done;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(restart),
        .tick_o   (tick)
    );

    // Frame FSM next state, shift capture and handshake update.
    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        done    = 1'b0;
        restart = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                os_d  = '0;
                bit_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                    restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == HALF_M1) begin
                        os_d    = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == FULL_M1) begin
                        os_d           = '0;
                        shift_d[bit_q] = rx_s_q;
                        bit_d          = bit_q + 1'b1;
                        if (bit_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (os_q == FULL_M1) begin
                        os_d    = '0;
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (os_q == FULL_M1) begin
                        os_d    = '0;
                        state_d = IDLE;
                        done    = rx_s_q;
                        ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shift_q, par_q};
`endif
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            os_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            sel_q     <= SEL_START;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            sel_q     <= state_sel(state_d);
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign mux_sel_o   = sel_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule
